tri_edge_scheduler: RTL and testbench

Sequencer for the triangle path of the graphics processor. On `go` it triggers the ROM-to-RAM loader and waits for it to finish. It then walks the vertex RAM one triangle record at a time and issues the three edges of each triangle, v0→v1, v1→v2 and v2→v0, to the line rasterizer over a start/done handshake. It sits between the loader/RAM pair and the line engine and is the only master of the RAM read port during a pass.

---
 rtl/tri_edge_scheduler_if.sv | 41 ++++
 rtl/tri_edge_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_tri_edge_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tri_edge_scheduler_if.sv
`default_nettype none
// ============================================================================
// tri_edge_scheduler_if : loader / vertex RAM / line engine signal bundle
// Revision: 1.0
// ============================================================================
interface tri_edge_scheduler_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int COORD_WIDTH = 10
) ();
    logic                   go;
    logic [ADDR_WIDTH-1:0]  num_tri;
    logic                   load_start;
    logic                   load_finish;
    logic [ADDR_WIDTH-1:0]  ram_addr;
    logic [DATA_WIDTH-1:0]  ram_data;
    logic                   line_start;
    logic [COORD_WIDTH-1:0] line_x0;
    logic [COORD_WIDTH-1:0] line_y0;
    logic [COORD_WIDTH-1:0] line_x1;
    logic [COORD_WIDTH-1:0] line_y1;
    logic                   line_done;
    logic                   busy;
    logic                   done;
    logic [ADDR_WIDTH-1:0]  tri_index;

    modport master (
        input  go, num_tri, load_finish, ram_data, line_done,
        output load_start, ram_addr, line_start,
               line_x0, line_y0, line_x1, line_y1,
               busy, done, tri_index
    );

    modport slave (
        output go, num_tri, load_finish, ram_data, line_done,
        input  load_start, ram_addr, line_start,
               line_x0, line_y0, line_x1, line_y1,
               busy, done, tri_index
    );
endinterface
`default_nettype wire

// File: rtl/tri_edge_scheduler.sv
`default_nettype none
// ============================================================================
// tri_edge_scheduler : loads vertex RAM, then issues three edges per triangle
// Optional: SKIP_DEGENERATE_EN drops zero-length edges.  Revision: 1.0
// ============================================================================
module tri_edge_scheduler #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int COORD_WIDTH = 10
) (
    input  wire logic            clk,
    input  wire logic            reset,
    tri_edge_scheduler_if.master bus
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_FETCH = 3'd2;
    localparam logic [2:0] c_ISSUE = 3'd3;
    localparam logic [2:0] c_WAIT  = 3'd4;
    localparam logic [2:0] c_NEXT  = 3'd5;
    localparam logic [2:0] c_DONE  = 3'd6;

    localparam logic [2:0]            c_WORDS  = 3'd6;
    localparam logic [ADDR_WIDTH-1:0] c_STRIDE = ADDR_WIDTH'(6);

    logic [2:0]                  r_state;
    logic [2:0]                  w_next_state;
    logic                        r_load_entry;
    logic [2:0]                  r_word;
    logic [1:0]                  r_edge;
    logic [ADDR_WIDTH-1:0]       r_num_tri;
    logic [ADDR_WIDTH-1:0]       r_tri_index;
    logic [ADDR_WIDTH-1:0]       r_base;
    logic [2:0][COORD_WIDTH-1:0] r_vx;
    logic [2:0][COORD_WIDTH-1:0] r_vy;
    logic [COORD_WIDTH-1:0]      r_lx0, r_ly0, r_lx1, r_ly1;

    logic [COORD_WIDTH-1:0]      w_coord;
    logic                        w_unused_bits;
    logic                        w_skip;
    logic                        w_last_edge;
    logic                        w_last_tri;
    logic                        w_enter_issue;
    logic [1:0]                  w_issue_edge;
    logic [COORD_WIDTH-1:0]      w_nx0, w_ny0, w_nx1, w_ny1;

    logic                        w_busy;
    logic                        w_done;
    logic                        w_load_start;
    logic                        w_line_start;
    logic [ADDR_WIDTH-1:0]       w_ram_addr;

    assign w_coord       = bus.ram_data[COORD_WIDTH-1:0];
    assign w_unused_bits = ^bus.ram_data[DATA_WIDTH-1:COORD_WIDTH];
    assign w_last_edge   = (r_edge == 2'd2);
    assign w_last_tri    = ((r_tri_index + ADDR_WIDTH'(1)) == r_num_tri);

    // The issued edge is always held in the line_* registers, so a
    // zero-length edge is detected directly on them.
`ifdef SKIP_DEGENERATE_EN
    assign w_skip = (r_lx0 == r_lx1) && (r_ly0 == r_ly1);
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.go) begin
                    w_next_state = c_LOAD;
                end
            end
            c_LOAD: begin
                if (bus.load_finish) begin
                    w_next_state = (r_num_tri == '0) ? c_DONE : c_FETCH;
                end
            end
            c_FETCH: begin
                if (r_word == c_WORDS) begin
                    w_next_state = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (w_skip) begin
                    w_next_state = w_last_edge ? c_NEXT : c_ISSUE;
                end else begin
                    w_next_state = c_WAIT;
                end
            end
            c_WAIT: begin
                if (bus.line_done) begin
                    w_next_state = w_last_edge ? c_NEXT : c_ISSUE;
                end
            end
            c_NEXT:  w_next_state = w_last_tri ? c_DONE : c_FETCH;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy       = (r_state != c_IDLE);
        w_done       = (r_state == c_DONE);
        w_load_start = (r_state == c_LOAD) && r_load_entry;
        w_line_start = (r_state == c_ISSUE) && !w_skip;
        w_ram_addr   = '0;
        // r_word == 6 is the trailing capture-only cycle
        if ((r_state == c_FETCH) && (r_word != c_WORDS)) begin
            w_ram_addr = r_base + ADDR_WIDTH'(r_word);
        end
    end

    assign w_enter_issue = (w_next_state == c_ISSUE);
    assign w_issue_edge  = (r_state == c_FETCH) ? 2'd0 : (r_edge + 2'd1);

    always_comb begin
        w_nx0 = r_vx[0];
        w_ny0 = r_vy[0];
        w_nx1 = r_vx[1];
        w_ny1 = r_vy[1];
        case (w_issue_edge)
            2'd1: begin
                w_nx0 = r_vx[1];
                w_ny0 = r_vy[1];
                w_nx1 = r_vx[2];
                w_ny1 = r_vy[2];
            end
            2'd2: begin
                w_nx0 = r_vx[2];
                w_ny0 = r_vy[2];
                w_nx1 = r_vx[0];
                w_ny1 = r_vy[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_entry <= 1'b0;
            r_word       <= '0;
            r_edge       <= '0;
            r_num_tri    <= '0;
            r_tri_index  <= '0;
            r_base       <= '0;
            r_vx         <= '0;
            r_vy         <= '0;
            r_lx0        <= '0;
            r_ly0        <= '0;
            r_lx1        <= '0;
            r_ly1        <= '0;
        end else begin
            r_load_entry <= (r_state == c_IDLE) && bus.go;

            if ((r_state == c_IDLE) && bus.go) begin
                r_num_tri   <= bus.num_tri;
                r_tri_index <= '0;
                r_base      <= '0;
            end

            if (r_state == c_NEXT) begin
                r_tri_index <= r_tri_index + ADDR_WIDTH'(1);
                r_base      <= r_base + c_STRIDE;
            end

            // RAM data lags the address by one cycle: word k lands at r_word k+1
            if (r_state == c_FETCH) begin
                r_word <= (r_word == c_WORDS) ? 3'd0 : (r_word + 3'd1);
                case (r_word)
                    3'd1:    r_vx[0] <= w_coord;
                    3'd2:    r_vy[0] <= w_coord;
                    3'd3:    r_vx[1] <= w_coord;
                    3'd4:    r_vy[1] <= w_coord;
                    3'd5:    r_vx[2] <= w_coord;
                    3'd6:    r_vy[2] <= w_coord;
                    default: ;
                endcase
            end

            if (w_enter_issue) begin
                r_edge <= w_issue_edge;
                r_lx0  <= w_nx0;
                r_ly0  <= w_ny0;
                r_lx1  <= w_nx1;
                r_ly1  <= w_ny1;
            end
        end
    end

    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.load_start = w_load_start;
    assign bus.line_start = w_line_start;
    assign bus.ram_addr   = w_ram_addr;
    assign bus.tri_index  = r_tri_index;
    assign bus.line_x0    = r_lx0;
    assign bus.line_y0    = r_ly0;
    assign bus.line_x1    = r_lx1;
    assign bus.line_y1    = r_ly1;

endmodule
`default_nettype wire

// File: tb/tb_tri_edge_scheduler.sv
`default_nettype none
// ============================================================================
// tb_tri_edge_scheduler : directed vectors for tri_edge_scheduler
// Revision: 1.0
// ============================================================================
module tb_tri_edge_scheduler;

    typedef logic [5:0][9:0] v6_t;
    typedef struct {
        v6_t              v;
        int               dly;
        int               ld;
        logic [2:0][39:0] exp_e;
    } vec_t;
    typedef struct {
        int          cyc;
        logic [7:0]  ti;
        logic [39:0] c;
    } edge_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    tri_edge_scheduler_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .COORD_WIDTH(10)) bus ();

    tri_edge_scheduler #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .COORD_WIDTH(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [31:0] ram [0:255];
    int  ld_dly = 0, ld_cnt = 0;
    int  rast_dly = 1, rast_cnt = 0, rast_k = 0;
    bit  rast_hold = 0, rast_var = 0;

    edge_t      edges_q[$];
    logic [7:0] addr_q[$];
    edge_t      m_e;
    logic [39:0] m_held;
    bit  mon_act = 0, lf_armed = 0;
    int  done_cnt = 0, ls_cnt = 0, stab_err = 0;
    int  ls_cyc = 0, lf_cyc = 0, done_cyc = 0;

    vec_t tbl [4];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.ram_data <= ram[bus.ram_addr];

    // Loader: drops finish on start, raises it ld_dly cycles later
    always @(posedge clk) begin
        #2;
        if (reset) begin
            bus.load_finish = 1'b0;
            ld_cnt = 0;
        end else if (bus.load_start) begin
            if (ld_dly == 0) bus.load_finish = 1'b1;
            else begin
                bus.load_finish = 1'b0;
                ld_cnt = ld_dly;
            end
        end else if (ld_cnt == 1) begin
            bus.load_finish = 1'b1;
            ld_cnt = 0;
        end else if (ld_cnt > 1) begin
            ld_cnt--;
        end
    end

    // Rasterizer: one-cycle done rast_dly cycles after start, or held high
    always @(posedge clk) begin
        #2;
        if (reset) begin
            rast_cnt = 0;
            bus.line_done = rast_hold;
        end else if (rast_hold) begin
            bus.line_done = 1'b1;
        end else if (bus.line_start) begin
            rast_cnt = rast_var ? 1 + (rast_k % 5) : rast_dly;
            rast_k++;
            bus.line_done = 1'b0;
        end else if (rast_cnt == 1) begin
            bus.line_done = 1'b1;
            rast_cnt = 0;
        end else begin
            if (rast_cnt > 1) rast_cnt--;
            bus.line_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            mon_act = 0;
        end else begin
            if (bus.load_start) begin
                ls_cnt++;
                ls_cyc = cyc;
                lf_armed = 1;
            end
            if (lf_armed && bus.load_finish) begin
                lf_cyc = cyc;
                lf_armed = 0;
            end
            if (bus.line_start) begin
                m_e.cyc = cyc;
                m_e.ti  = bus.tri_index;
                m_e.c   = {bus.line_x0, bus.line_y0, bus.line_x1, bus.line_y1};
                edges_q.push_back(m_e);
                m_held  = m_e.c;
                mon_act = 1;
            end else if (mon_act) begin
                if ({bus.line_x0, bus.line_y0, bus.line_x1, bus.line_y1} !== m_held) stab_err++;
                if (bus.line_done) mon_act = 0;
            end
            if (bus.ram_addr != 8'd0) addr_q.push_back(bus.ram_addr);
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    function automatic v6_t mk6(input int a, input int b, input int c, input int d,
                                input int e, input int f);
        return {10'(f), 10'(e), 10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    function automatic logic [39:0] mke(input int x0, input int y0, input int x1, input int y1);
        return {10'(x0), 10'(y0), 10'(x1), 10'(y1)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_tri(input int t, input v6_t v);
        for (int k = 0; k < 6; k++) ram[8'(t * 6 + k)] = {22'h3ABCD, v[k]};
    endtask

    task automatic clear_logs();
        edges_q.delete();
        addr_q.delete();
        done_cnt = 0;
        ls_cnt   = 0;
        stab_err = 0;
        mon_act  = 0;
        lf_armed = 0;
        rast_k   = 0;
    endtask

    task automatic run_pass(input logic [7:0] nt);
        bus.num_tri = nt;
        bus.go = 1'b1;
        step(1);
        bus.go = 1'b0;
        for (int i = 0; i < 3000 && done_cnt == 0; i++) step(1);
        check("pass_done_seen", (done_cnt != 0), 1);
        step(2);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        bus.go = 1'b0;
        bus.num_tri = 8'd0;

        tbl[0].v = mk6(10, 20, 30, 40, 50, 60); tbl[0].dly = 1; tbl[0].ld = 0;
        tbl[0].exp_e = {mke(50, 60, 10, 20), mke(30, 40, 50, 60), mke(10, 20, 30, 40)};
        tbl[1].v = mk6(0, 0, 1023, 0, 0, 1023); tbl[1].dly = 3; tbl[1].ld = 1;
        tbl[1].exp_e = {mke(0, 1023, 0, 0), mke(1023, 0, 0, 1023), mke(0, 0, 1023, 0)};
        tbl[2].v = mk6(100, 200, 300, 400, 500, 600); tbl[2].dly = 5; tbl[2].ld = 4;
        tbl[2].exp_e = {mke(500, 600, 100, 200), mke(300, 400, 500, 600), mke(100, 200, 300, 400)};
        tbl[3].v = mk6(7, 8, 7, 9, 1000, 8); tbl[3].dly = 2; tbl[3].ld = 2;
        tbl[3].exp_e = {mke(1000, 8, 7, 8), mke(7, 9, 1000, 8), mke(7, 8, 7, 9)};

        // Reset values
        step(3);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_load_start", bus.load_start, 0);
        check("rst_line_start", bus.line_start, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_tri_index", bus.tri_index, 0);
        check("rst_coords", {bus.line_x0, bus.line_y0, bus.line_x1, bus.line_y1}, 0);
        reset = 1'b0;
        step(2);

        // Cycle-exact single triangle: go at C0, finish at C0+3, first edge at C0+11
        clear_logs();
        load_tri(0, tbl[0].v);
        ld_dly = 2;
        rast_dly = 1;
        bus.num_tri = 8'd1;
        bus.go = 1'b1;
        step(1);
        bus.go = 1'b0;
        check("t_load_start_c1", bus.load_start, 1);
        check("t_busy_c1", bus.busy, 1);
        step(1);
        check("t_load_start_c2", bus.load_start, 0);
        step(3);
        check("t_addr_c5", bus.ram_addr, 1);
        step(4);
        check("t_addr_c9", bus.ram_addr, 5);
        step(1);
        check("t_addr_c10", bus.ram_addr, 0);
        check("t_line_start_c10", bus.line_start, 0);
        step(1);
        check("t_line_start_c11", bus.line_start, 1);
        check("t_edge0", {bus.line_x0, bus.line_y0, bus.line_x1, bus.line_y1}, mke(10, 20, 30, 40));
        step(1);
        check("t_line_start_c12", bus.line_start, 0);
        step(1);
        check("t_line_start_c13", bus.line_start, 1);
        check("t_edge1", {bus.line_x0, bus.line_y0, bus.line_x1, bus.line_y1}, mke(30, 40, 50, 60));
        step(2);
        check("t_line_start_c15", bus.line_start, 1);
        check("t_edge2", {bus.line_x0, bus.line_y0, bus.line_x1, bus.line_y1}, mke(50, 60, 10, 20));
        step(3);
        check("t_done_c18", bus.done, 1);
        check("t_busy_c18", bus.busy, 1);
        step(1);
        check("t_done_c19", bus.done, 0);
        check("t_busy_c19", bus.busy, 0);
        check("t_tri_index_end", bus.tri_index, 1);
        check("t_coords_held", {bus.line_x0, bus.line_y0, bus.line_x1, bus.line_y1}, mke(50, 60, 10, 20));
        check("t_done_count", done_cnt, 1);
        step(2);

        // Table of single-triangle vectors
        for (int i = 0; i < 4; i++) begin
            clear_logs();
            load_tri(0, tbl[i].v);
            ld_dly = tbl[i].ld;
            rast_dly = tbl[i].dly;
            run_pass(8'd1);
            check("vec_edge_count", edges_q.size(), 3);
            for (int k = 0; k < 3 && k < edges_q.size(); k++) begin
                check("vec_coords", edges_q[k].c, tbl[i].exp_e[k]);
                check("vec_tri_index", edges_q[k].ti, 0);
            end
            check("vec_done_count", done_cnt, 1);
            check("vec_stable", stab_err, 0);
        end

        // Two triangles, variable rasterizer latency 1..5
        clear_logs();
        load_tri(0, tbl[0].v);
        load_tri(1, mk6(11, 12, 13, 14, 15, 16));
        ld_dly = 1;
        rast_var = 1;
        run_pass(8'd2);
        rast_var = 0;
        check("two_edge_count", edges_q.size(), 6);
        for (int k = 0; k < 6 && k < edges_q.size(); k++) begin
            check("two_tri_index", edges_q[k].ti, k / 3);
        end
        if (edges_q.size() == 6) begin
            check("two_e3", edges_q[3].c, mke(11, 12, 13, 14));
            check("two_e4", edges_q[4].c, mke(13, 14, 15, 16));
            check("two_e5", edges_q[5].c, mke(15, 16, 11, 12));
        end
        check("two_addr_count", addr_q.size(), 11);
        for (int k = 0; k < 11 && k < addr_q.size(); k++) check("two_addr_seq", addr_q[k], k + 1);
        check("two_stable", stab_err, 0);
        check("two_done_count", done_cnt, 1);

        // Zero triangles
        clear_logs();
        ld_dly = 3;
        run_pass(8'd0);
        check("zero_load_start", ls_cnt, 1);
        check("zero_done_after_finish", done_cyc - lf_cyc, 1);
        check("zero_done_after_start", done_cyc - ls_cyc, 4);
        check("zero_no_edges", edges_q.size(), 0);
        check("zero_no_addr", addr_q.size(), 0);
        check("zero_done_count", done_cnt, 1);

        // line_done held high, extra go while busy
        clear_logs();
        load_tri(0, tbl[0].v);
        ld_dly = 0;
        rast_hold = 1;
        step(1);
        bus.num_tri = 8'd1;
        bus.go = 1'b1;
        step(1);
        bus.go = 1'b0;
        step(5);
        bus.go = 1'b1;
        step(1);
        bus.go = 1'b0;
        for (int i = 0; i < 200 && done_cnt == 0; i++) step(1);
        step(10);
        rast_hold = 0;
        check("hold_edge_count", edges_q.size(), 3);
        if (edges_q.size() == 3) begin
            check("hold_spacing01", edges_q[1].cyc - edges_q[0].cyc, 2);
            check("hold_spacing12", edges_q[2].cyc - edges_q[1].cyc, 2);
            check("hold_edge2", edges_q[2].c, mke(50, 60, 10, 20));
        end
        check("hold_done_count", done_cnt, 1);
        check("hold_load_count", ls_cnt, 1);
        check("hold_idle_after", bus.busy, 0);
        step(2);

        // Reset while waiting on edge 1
        clear_logs();
        load_tri(0, tbl[0].v);
        rast_dly = 5;
        bus.num_tri = 8'd1;
        bus.go = 1'b1;
        step(1);
        bus.go = 1'b0;
        for (int i = 0; i < 200 && edges_q.size() < 2; i++) step(1);
        check("rw_reached_edge1", edges_q.size(), 2);
        check("rw_busy_before", bus.busy, 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rw_busy", bus.busy, 0);
        check("rw_coords", {bus.line_x0, bus.line_y0, bus.line_x1, bus.line_y1}, 0);
        check("rw_ram_addr", bus.ram_addr, 0);
        step(8);
        check("rw_no_done", done_cnt, 0);
        clear_logs();
        rast_dly = 2;
        run_pass(8'd1);
        check("rw_restart_edges", edges_q.size(), 3);
        if (edges_q.size() > 0) begin
            check("rw_restart_edge0", edges_q[0].c, mke(10, 20, 30, 40));
            check("rw_restart_tri", edges_q[0].ti, 0);
        end
        check("rw_restart_done", done_cnt, 1);

        // Triangle with a zero-length first edge
        clear_logs();
        load_tri(0, mk6(5, 5, 5, 5, 9, 9));
        rast_dly = 1;
        ld_dly = 0;
        run_pass(8'd1);
`ifdef SKIP_DEGENERATE_EN
        check("degen_edge_count", edges_q.size(), 2);
        if (edges_q.size() == 2) begin
            check("degen_e0", edges_q[0].c, mke(5, 5, 9, 9));
            check("degen_e1", edges_q[1].c, mke(9, 9, 5, 5));
        end
`else
        check("degen_edge_count", edges_q.size(), 3);
        if (edges_q.size() == 3) begin
            check("degen_e0", edges_q[0].c, mke(5, 5, 5, 5));
            check("degen_e2", edges_q[2].c, mke(9, 9, 5, 5));
        end
`endif
        check("degen_done", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
`default_nettype wire
